// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver and its companion transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_e;

  localparam int DATA_BITS_MAX = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle pulse every CLK_DIV clocks, restartable so the
// tick phase can be aligned to a detected start edge.
module uart_baud_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Down-counter; i_clear reloads it so the first tick lands a full period after the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clear || (cnt_q == '0)) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_tick = (cnt_q == '0) && !i_clear;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample majority vote, start-glitch rejection,
// parity/framing error flags and a valid/ready output register with overrun pulse.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | line idle; armed for a 1->0 edge on the synchronised line
//   ST_START  | verifying start bit at mid-bit; voted 1 means glitch -> IDLE
//   ST_DATA   | shifting DATA_BITS voted bits, LSB first
//   ST_PARITY | voting the parity bit and comparing against the data
//   ST_STOP   | voting stop bit(s); leaves at mid-bit of the last stop bit
//   ST_DONE   | one cycle: load output register or flag overrun
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int      CLK_DIV   = 4,
  parameter int      OVS       = 16,
  parameter int      DATA_BITS = 8,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVS / 2);
  localparam logic [SW-1:0] S_VOTE = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_END  = SW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] P_LAST = BW'(STOP_BITS - 1);

  rx_state_e            state_q;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [SW-1:0]        smp_q;
  logic [BW-1:0]        bit_q;
  logic                 s0_q, s1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 data_perr_q, data_ferr_q, valid_q, overrun_q;

  logic tick, start_edge, vote_d, at_vote, at_end;

  assign start_edge = (state_q == ST_IDLE) && rx_prev_q && !rx_s_q;
  assign vote_d     = maj3(s0_q, s1_q, rx_s_q);
  assign at_vote    = tick && (smp_q == S_VOTE);
  assign at_end     = tick && (smp_q == S_END);

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(start_edge),
    .o_tick (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      smp_q       <= '0;
      bit_q       <= '0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      data_q      <= '0;
      data_perr_q <= 1'b0;
      data_ferr_q <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      overrun_q <= 1'b0;
      if (valid_q && i_ready) valid_q <= 1'b0;
      if ((state_q != ST_IDLE) && tick) smp_q <= smp_q + 1'b1;
      if (tick && (smp_q == S_V0)) s0_q <= rx_s_q;
      if (tick && (smp_q == S_V1)) s1_q <= rx_s_q;

      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_q <= ST_START;
            smp_q   <= '0;
            bit_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (at_vote && vote_d) state_q <= ST_IDLE;
          else if (at_end) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (at_vote) shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_q == B_LAST) begin
              bit_q   <= '0;
              state_q <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (at_vote) perr_q <= (^{shift_q, vote_d}) != (PARITY == PAR_ODD);
          if (at_end) state_q <= ST_STOP;
        end
        ST_STOP: begin
          // Leave at mid-bit of the last stop bit to leave resync margin for the next start edge.
          if (at_vote) begin
            if (!vote_d) ferr_q <= 1'b1;
            if (bit_q == P_LAST) state_q <= ST_DONE;
          end else if (at_end) begin
            bit_q <= bit_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (!valid_q || i_ready) begin
            data_q      <= shift_q;
            data_perr_q <= perr_q;
            data_ferr_q <= ferr_q;
            valid_q     <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_parity_err = data_perr_q;
  assign o_frame_err  = data_ferr_q;
  assign o_valid      = valid_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule
